// File: rtl/inst_stream_encoder.sv
// rtl/inst_stream_encoder.sv - symbolic instruction to MIPS word encoder and program loader
// Writes encoded words into instruction memory, then releases the core.
module inst_stream_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              core_run,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_ERROR} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic              last_q;
  logic [31:0]       word;
  logic              legal;
  logic              accept;

  // Opcode/funct map shared with the pipeline decoder
  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (in_op)
      4'd0:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100000};
      4'd1:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100010};
      4'd2:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100100};
      4'd3:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b100101};
      4'd4:    word = {6'b000000, in_rs, in_rt, in_rd, 5'b0, 6'b101010};
      4'd5:    word = {6'b100011, in_rs, in_rt, in_imm};
      4'd6:    word = {6'b101011, in_rs, in_rt, in_imm};
      4'd7:    word = {6'b000100, in_rs, in_rt, in_imm};
      4'd8:    word = {6'b000101, in_rs, in_rt, in_imm};
      4'd9:    word = {6'b001000, in_rs, in_rt, in_imm};
      4'd10:   word = {6'b001100, in_rs, in_rt, in_imm};
      4'd11:   word = {6'b000010, in_target};
      default: legal = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    core_run  = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = legal ? S_WRITE : S_ERROR;
      end
      S_WRITE: begin
        if (mem_ack) state_nxt = (last_q || wptr == LAST_ADDR) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        done     = 1'b1;
        core_run = 1'b1;
        if (start) state_nxt = S_IDLE;
      end
      S_ERROR: begin
        err = 1'b1;
        if (start) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // wptr saturates at the last address so no write can land past the end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      last_q    <= 1'b0;
      full      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && legal) begin
            mem_wdata <= word;
            mem_addr  <= wptr;
            last_q    <= in_last;
            mem_we    <= 1'b1;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            count  <= count + (ADDR_W+1)'(1);
            if (wptr == LAST_ADDR) full <= 1'b1;
            else                   wptr <= wptr + ADDR_W'(1);
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            wptr  <= '0;
            count <= '0;
            full  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_stream_encoder.sv
// tb/tb_inst_stream_encoder.sv - scoreboard bench for inst_stream_encoder
// Expected writes are queued at issue time; a negedge monitor acks and compares.
module tb_inst_stream_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, in_valid, in_last, mem_ack;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_ready, mem_we, core_run, done, full, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] count;

  logic        s_in_valid;
  logic        s_in_ready, s_mem_we, s_mem_ack, s_core_run, s_done, s_full, s_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [2:0]  s_count;

  int tests = 0;
  int fails = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int s_wr_cnt = 0;
  logic [9:0]  hold_addr;
  logic [31:0] hold_data;
  logic [9:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always #5 clk = ~clk;

  inst_stream_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .core_run(core_run), .done(done),
    .full(full), .err(err), .count(count)
  );

  assign s_mem_ack = s_mem_we;

  inst_stream_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_op(4'd0), .in_rs(5'd1), .in_rt(5'd2), .in_rd(5'd3), .in_imm(16'h0),
    .in_target(26'h0), .in_last(1'b0), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_ack(s_mem_ack), .core_run(s_core_run), .done(s_done),
    .full(s_full), .err(s_err), .count(s_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ack generator and scoreboard monitor for the main instance
  always @(negedge clk) begin
    if (rst || !mem_we) begin
      wait_cnt = 0;
      mem_ack  = 1'b0;
    end else begin
      if (wait_cnt == 0) begin
        hold_addr = mem_addr;
        hold_data = mem_wdata;
      end else begin
        chk("hold_addr", mem_addr, hold_addr);
        chk("hold_data", mem_wdata, hold_data);
      end
      mem_ack = (wait_cnt >= ack_delay);
      wait_cnt++;
      if (mem_ack) begin
        if (exp_data_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
        end else begin
          chk("wr_addr", mem_addr, exp_addr_q.pop_front());
          chk("wr_data", mem_wdata, exp_data_q.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s_mem_we) begin
      chk("s_wr_addr", s_mem_addr, s_wr_cnt[1:0]);
      s_wr_cnt++;
    end
  end

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input logic legal, input logic [31:0] exp_word,
                      input logic [9:0] exp_addr);
    int t = 0;
    @(negedge clk);
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
    in_last = last; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready 0 required 1");
    end else if (legal) begin
      exp_addr_q.push_back(exp_addr);
      exp_data_q.push_back(exp_word);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && !err && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_op = 4'd0;
    in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'h0; in_target = 26'h0;
    s_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 10'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_core_run", core_run, 1'b0);
    chk("rst_flags", {done, full, err}, 3'b000);
    chk("rst_count", count, 11'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);

    // Two-word program, same-cycle ack
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820, 10'd0);
    send(4'd5, 5'd0, 5'd4, 5'd0, 16'h8, 26'h0, 1'b1, 1'b1, 32'h8C040008, 10'd1);
    wait_done();
    chk("t1_core_run", core_run, 1'b1);
    chk("t1_count", count, 11'd2);
    chk("t1_full", full, 1'b0);
    chk("t1_in_ready", in_ready, 1'b0);

    // Delayed ack, unused fields carry junk
    pulse_start();
    ack_delay = 3;
    send(4'd7, 5'd1, 5'd2, 5'd9, 16'hFFFF, 26'h3FFFFFF, 1'b0, 1'b1, 32'h1022FFFF, 10'd0);
    send(4'd10, 5'd5, 5'd5, 5'd7, 16'h00FF, 26'h0, 1'b0, 1'b1, 32'h30A500FF, 10'd1);
    send(4'd11, 5'd7, 5'd7, 5'd7, 16'h1234, 26'h10, 1'b1, 1'b1, 32'h08000010, 10'd2);
    wait_done();
    chk("t2_count", count, 11'd3);
    @(negedge clk);
    ack_delay = 0;

    // Illegal op
    pulse_start();
    send(4'd13, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1, 1'b0, 1'b0, 32'h0, 10'd0);
    repeat (3) @(negedge clk);
    chk("t4_err", err, 1'b1);
    chk("t4_core_run", core_run, 1'b0);
    chk("t4_in_ready", in_ready, 1'b0);
    chk("t4_mem_we", mem_we, 1'b0);
    chk("t4_done", done, 1'b0);
    pulse_start();
    chk("t4_err_clr", err, 1'b0);
    chk("t4_in_ready_clr", in_ready, 1'b1);
    chk("t4_count_clr", count, 11'd0);

    // Reset during a pending write
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221820, 10'd0);
    @(negedge clk);
    ack_delay = 5;
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221822, 10'd1);
    chk("t5_pending_we", mem_we, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_mem_we", mem_we, 1'b0);
    chk("t5_rst_mem_addr", mem_addr, 10'h0);
    chk("t5_rst_wdata", mem_wdata, 32'h0);
    chk("t5_rst_count", count, 11'd0);
    chk("t5_rst_in_ready", in_ready, 1'b1);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    send(4'd5, 5'd0, 5'd4, 5'd0, 16'h8, 26'h0, 1'b1, 1'b1, 32'h8C040008, 10'd0);
    wait_done();
    chk("t5_count", count, 11'd1);

    // start with in_valid in the same cycle, then the remaining ops
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_op = 4'd1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("t6_done", done, 1'b0);
    chk("t6_count", count, 11'd0);
    chk("t6_core_run", core_run, 1'b0);
    chk("t6_mem_we", mem_we, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h0, 1'b0, 1'b1, 32'h00221822, 10'd0);
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221824, 10'd1);
    send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00221825, 10'd2);
    send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022182A, 10'd3);
    send(4'd6, 5'd2, 5'd3, 5'd0, 16'h4, 26'h0, 1'b0, 1'b1, 32'hAC430004, 10'd4);
    send(4'd8, 5'd1, 5'd2, 5'd0, 16'h10, 26'h0, 1'b0, 1'b1, 32'h14220010, 10'd5);
    send(4'd9, 5'd0, 5'd1, 5'd0, 16'h5, 26'h0, 1'b1, 1'b1, 32'h20010005, 10'd6);
    wait_done();
    chk("t6_final_count", count, 11'd7);
    chk("t6_final_run", core_run, 1'b1);

    // Small memory fills up without in_last
    @(negedge clk);
    s_in_valid = 1'b1;
    for (int t = 0; t < 100 && !s_done; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("t3_done", s_done, 1'b1);
    chk("t3_full", s_full, 1'b1);
    chk("t3_count", s_count, 3'd4);
    chk("t3_in_ready", s_in_ready, 1'b0);
    chk("t3_writes", s_wr_cnt, 4);
    chk("t3_core_run", s_core_run, 1'b1);
    s_in_valid = 1'b0;

    chk("queue_drained", exp_data_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
